// File: rtl/ps_link_pkg.sv
// Shared definitions for the power-supply setpoint link: arbiter state encoding,
// counter width and the stream beat used by the AWG and the link serializer.
package ps_link_pkg;

    localparam int PS_COUNT_WIDTH = 16;
    localparam int PS_DATA_WIDTH  = 32;

    typedef enum logic [1:0] {
        ST_FOFB       = 2'd0,
        ST_AWG        = 2'd1,
        ST_DRAIN_FOFB = 2'd2,
        ST_DRAIN_AWG  = 2'd3
    } ps_state_e;

    typedef struct packed {
        logic [PS_DATA_WIDTH-1:0] data;
        logic                     valid;
        logic                     last;
    } ps_beat_t;

    // Saturating add of a small increment onto a status counter.
    function automatic logic [PS_COUNT_WIDTH-1:0] sat_add(
        input logic [PS_COUNT_WIDTH-1:0] value,
        input logic [1:0]                inc
    );
        logic [PS_COUNT_WIDTH:0] sum;
        sum = {1'b0, value} + {{(PS_COUNT_WIDTH - 1){1'b0}}, inc};
        return sum[PS_COUNT_WIDTH] ? '1 : sum[PS_COUNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/ps_packet_tracker.sv
// Per-source packet tracker: in-packet and clean flags, forward/drop strobes and
// the in-packet watchdog, which only runs while this source owns the link.
module ps_packet_tracker #(
    parameter int WATCHDOG_CYCLES = 1000
) (
    input  logic sysClk,
    input  logic sysReset,
    input  logic valid,
    input  logic last,
    input  logic owner,
    output logic in_packet,
    output logic forward,
    output logic drop,
    output logic expire
);

    localparam int                  WD_WIDTH = $clog2(WATCHDOG_CYCLES);
    localparam logic [WD_WIDTH-1:0] WD_LOAD  = WD_WIDTH'(WATCHDOG_CYCLES - 1);

    logic                in_packet_q, in_packet_d;
    logic                clean_q, clean_d;
    logic [WD_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path can infer a latch.
        in_packet_d = in_packet_q;
        clean_d     = clean_q;
        forward     = valid & owner & (~in_packet_q | clean_q);
        drop        = valid & last & ~forward;
        expire      = owner & in_packet_q & ~valid & (wd_cnt_q == '0);

        if (valid) begin
            if (last) begin
                in_packet_d = 1'b0;
                clean_d     = 1'b0;
            end else if (!in_packet_q) begin
                in_packet_d = 1'b1;
                clean_d     = owner;
            end
        end else if (expire) begin
            in_packet_d = 1'b0;
            clean_d     = 1'b0;
        end

        // Held at full reload until the owner is silent inside a packet.
        if (valid || !owner || !in_packet_q) begin
            wd_cnt_d = WD_LOAD;
        end else begin
            wd_cnt_d = wd_cnt_q - WD_WIDTH'(1);
        end
    end

    always_ff @(posedge sysClk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (sysReset) begin
            in_packet_q <= 1'b0;
            clean_q     <= 1'b0;
            wd_cnt_q    <= WD_LOAD;
        end else begin
            in_packet_q <= in_packet_d;
            clean_q     <= clean_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign in_packet = in_packet_q;

endmodule

// File: rtl/ps_setpoint_arbiter.sv
// Arbitrates the PS setpoint link between the FOFB and AWG sources, handing
// ownership over only on packet boundaries and driving the AWG enable handshake.
module ps_setpoint_arbiter
    import ps_link_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int WATCHDOG_CYCLES = 1000
) (
    input  logic                      sysClk,
    input  logic                      sysReset,
    input  logic [DATA_WIDTH-1:0]     fofbTDATA,
    input  logic                      fofbTVALID,
    input  logic                      fofbTLAST,
    input  logic [DATA_WIDTH-1:0]     awgTDATA,
    input  logic                      awgTVALID,
    input  logic                      awgTLAST,
    input  logic                      AWGrequest,
    output logic                      AWGenabled,
    output logic [DATA_WIDTH-1:0]     psTDATA,
    output logic                      psTVALID,
    output logic                      psTLAST,
    output logic                      psAbort,
    output logic [PS_COUNT_WIDTH-1:0] droppedCount,
    output logic [PS_COUNT_WIDTH-1:0] abortCount
);

    ps_state_e state_q, state_d;

    logic fofb_owner, awg_owner;
    logic fofb_in_packet, fofb_forward, fofb_drop, fofb_expire;
    logic awg_in_packet, awg_forward, awg_drop, awg_expire;
    logic fofb_idle, awg_idle;

    logic [DATA_WIDTH-1:0]     ps_data_q, ps_data_d;
    logic                      ps_valid_q, ps_valid_d;
    logic                      ps_last_q, ps_last_d;
    logic                      ps_abort_q, ps_abort_d;
    logic                      awg_enabled_q, awg_enabled_d;
    logic [PS_COUNT_WIDTH-1:0] dropped_count_q, dropped_count_d;
    logic [PS_COUNT_WIDTH-1:0] abort_count_q, abort_count_d;

    // Beats are always judged against the owner before any state change this cycle.
    assign fofb_owner = (state_q == ST_FOFB) || (state_q == ST_DRAIN_FOFB);
    assign awg_owner  = ~fofb_owner;
    assign fofb_idle  = ~fofb_in_packet & ~fofbTVALID;
    assign awg_idle   = ~awg_in_packet & ~awgTVALID;

    ps_packet_tracker #(.WATCHDOG_CYCLES(WATCHDOG_CYCLES)) u_fofb_tracker (
        .sysClk    (sysClk),
        .sysReset  (sysReset),
        .valid     (fofbTVALID),
        .last      (fofbTLAST),
        .owner     (fofb_owner),
        .in_packet (fofb_in_packet),
        .forward   (fofb_forward),
        .drop      (fofb_drop),
        .expire    (fofb_expire)
    );

    ps_packet_tracker #(.WATCHDOG_CYCLES(WATCHDOG_CYCLES)) u_awg_tracker (
        .sysClk    (sysClk),
        .sysReset  (sysReset),
        .valid     (awgTVALID),
        .last      (awgTLAST),
        .owner     (awg_owner),
        .in_packet (awg_in_packet),
        .forward   (awg_forward),
        .drop      (awg_drop),
        .expire    (awg_expire)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FOFB: begin
                if (AWGrequest) state_d = fofb_idle ? ST_AWG : ST_DRAIN_FOFB;
            end
            ST_DRAIN_FOFB: begin
                if (!AWGrequest)    state_d = ST_FOFB;
                else if (fofb_idle) state_d = ST_AWG;
            end
            ST_AWG: begin
                if (!AWGrequest) state_d = awg_idle ? ST_FOFB : ST_DRAIN_AWG;
            end
            ST_DRAIN_AWG: begin
                if (AWGrequest)    state_d = ST_AWG;
                else if (awg_idle) state_d = ST_FOFB;
            end
            default: state_d = ST_FOFB;
        endcase
    end

    always_comb begin
        ps_valid_d      = fofb_forward | awg_forward;
        ps_last_d       = (fofb_forward & fofbTLAST) | (awg_forward & awgTLAST);
        ps_data_d       = fofb_forward ? fofbTDATA : (awg_forward ? awgTDATA : '0);
        ps_abort_d      = fofb_expire | awg_expire;
        awg_enabled_d   = (state_d == ST_AWG) || (state_d == ST_DRAIN_AWG);
        dropped_count_d = sat_add(dropped_count_q, {1'b0, fofb_drop} + {1'b0, awg_drop});
        abort_count_d   = sat_add(abort_count_q, {1'b0, ps_abort_d});
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q         <= ST_FOFB;
            ps_data_q       <= '0;
            ps_valid_q      <= 1'b0;
            ps_last_q       <= 1'b0;
            ps_abort_q      <= 1'b0;
            awg_enabled_q   <= 1'b0;
            dropped_count_q <= '0;
            abort_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            ps_data_q       <= ps_data_d;
            ps_valid_q      <= ps_valid_d;
            ps_last_q       <= ps_last_d;
            ps_abort_q      <= ps_abort_d;
            awg_enabled_q   <= awg_enabled_d;
            dropped_count_q <= dropped_count_d;
            abort_count_q   <= abort_count_d;
        end
    end

    assign AWGenabled   = awg_enabled_q;
    assign psTDATA      = ps_data_q;
    assign psTVALID     = ps_valid_q;
    assign psTLAST      = ps_last_q;
    assign psAbort      = ps_abort_q;
    assign droppedCount = dropped_count_q;
    assign abortCount   = abort_count_q;

endmodule

// File: tb/tb_ps_setpoint_arbiter.sv
// Self-checking bench for ps_setpoint_arbiter: directed scenarios plus random
// traffic, compared against a packet-level ownership model kept in the bench.
module tb_ps_setpoint_arbiter;

    localparam int DW = 32;
    localparam int WD = 8;

    logic          sysClk = 1'b0;
    logic          sysReset;
    logic [DW-1:0] fofbTDATA, awgTDATA, psTDATA;
    logic          fofbTVALID, fofbTLAST, awgTVALID, awgTLAST, AWGrequest;
    logic          AWGenabled, psTVALID, psTLAST, psAbort;
    logic [15:0]   droppedCount, abortCount;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: who owns the link, per-source packet status, idle gap.
    int            m_owner;
    bit            m_inpkt[2];
    bit            m_clean[2];
    int            m_gap[2];
    int            m_dropped, m_aborts;
    bit            e_valid, e_last, e_abort, e_en;
    logic [DW-1:0] e_data;

    always #5 sysClk = ~sysClk;

    ps_setpoint_arbiter #(.DATA_WIDTH(DW), .WATCHDOG_CYCLES(WD)) dut (
        .sysClk       (sysClk),
        .sysReset     (sysReset),
        .fofbTDATA    (fofbTDATA),
        .fofbTVALID   (fofbTVALID),
        .fofbTLAST    (fofbTLAST),
        .awgTDATA     (awgTDATA),
        .awgTVALID    (awgTVALID),
        .awgTLAST     (awgTLAST),
        .AWGrequest   (AWGrequest),
        .AWGenabled   (AWGenabled),
        .psTDATA      (psTDATA),
        .psTVALID     (psTVALID),
        .psTLAST      (psTLAST),
        .psAbort      (psAbort),
        .droppedCount (droppedCount),
        .abortCount   (abortCount)
    );

    function automatic logic [67:0] obs_vec();
        return {AWGenabled, psAbort, psTVALID, psTLAST, psTDATA, droppedCount, abortCount};
    endfunction

    function automatic logic [67:0] exp_vec();
        return {e_en, e_abort, e_valid, e_last, e_data, 16'(m_dropped), 16'(m_aborts)};
    endfunction

    // Ownership flips toward the request whenever the current owner is between packets.
    task automatic model_step(input bit rst, input bit req,
                              input bit fv, input bit fl, input logic [DW-1:0] fd,
                              input bit av, input bit al, input logic [DW-1:0] ad);
        bit            v[2], l[2], busy[2];
        logic [DW-1:0] d[2];
        bit            own, fwd, expd;
        v = '{fv, av}; l = '{fl, al}; d = '{fd, ad};
        e_valid = 0; e_last = 0; e_data = '0; e_abort = 0;
        if (rst) begin
            m_owner = 0; m_inpkt = '{0, 0}; m_clean = '{0, 0}; m_gap = '{0, 0};
            m_dropped = 0; m_aborts = 0; e_en = 0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                own     = (m_owner == s);
                fwd     = v[s] && own && (!m_inpkt[s] || m_clean[s]);
                busy[s] = m_inpkt[s] || v[s];
                expd    = 0;
                if (own && m_inpkt[s] && !v[s]) begin
                    m_gap[s]++;
                    expd = (m_gap[s] >= WD);
                end else begin
                    m_gap[s] = 0;
                end
                if (fwd) begin e_valid = 1; e_last = l[s]; e_data = d[s]; end
                if (v[s] && l[s] && !fwd && m_dropped < 65535) m_dropped++;
                if (expd) begin e_abort = 1; if (m_aborts < 65535) m_aborts++; end
                if (v[s]) begin
                    if (l[s]) begin m_inpkt[s] = 0; m_clean[s] = 0; end
                    else if (!m_inpkt[s]) begin m_inpkt[s] = 1; m_clean[s] = own; end
                end else if (expd) begin
                    m_inpkt[s] = 0; m_clean[s] = 0;
                end
            end
            if (int'(req) != m_owner && !busy[m_owner]) m_owner = int'(req);
            e_en = (m_owner == 1);
        end
    endtask

    task automatic drive_cycle(input bit rst, input bit req,
                               input bit fv, input bit fl, input logic [DW-1:0] fd,
                               input bit av, input bit al, input logic [DW-1:0] ad);
        sysReset = rst; AWGrequest = req;
        fofbTVALID = fv; fofbTLAST = fl; fofbTDATA = fd;
        awgTVALID = av; awgTLAST = al; awgTDATA = ad;
        model_step(rst, req, fv, fl, fd, av, al, ad);
        @(posedge sysClk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [DW-1:0] sent[$];
        logic [DW-1:0] w;
        bit            v;
        int            beats = 0;
        repeat (3) drive_cycle(1, 0, 1, 0, $urandom, 1, 1, $urandom);
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", obs_vec());
        end
        checks++;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 20; c++) begin
                v = (c < 3);
                w = v ? DW'($urandom) : '0;
                if (v) sent.push_back(w);
                drive_cycle(0, 0, v, c == 2, w, 0, 0, '0);
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL reset_traffic cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
                end
                checks++;
                if (psTVALID) begin
                    beats++;
                    if (sent.size() == 0 || psTDATA !== sent[0]) begin
                        errors++; $display("FAIL reset_order cyc=%0d got=%h", cyc, psTDATA);
                    end
                    checks++;
                    if (sent.size() != 0) void'(sent.pop_front());
                end
            end
        end
        if (beats != 9 || AWGenabled !== 1'b0 || droppedCount !== 16'd0 || abortCount !== 16'd0) begin
            errors++; $display("FAIL reset_summary beats=%0d en=%b drop=%0d abort=%0d want 9/0/0/0",
                               beats, AWGenabled, droppedCount, abortCount);
        end
        checks++;
    endtask

    task automatic test_request_mid_packet();
        bit v, req;
        for (int i = 0; i < 6; i++) begin
            v = (i < 3); req = (i >= 1);
            drive_cycle(0, req, v, i == 2, v ? DW'(100 + i) : '0, v, i == 2, v ? DW'(200 + i) : '0);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL req_mid cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (i == 2 && {psTVALID, psTLAST, psTDATA, AWGenabled} !== {1'b1, 1'b1, 32'd102, 1'b0}) begin
                errors++; $display("FAIL req_mid_last got v=%b l=%b d=%0d en=%b want 1/1/102/0",
                                   psTVALID, psTLAST, psTDATA, AWGenabled);
            end
            if (i == 3 && AWGenabled !== 1'b1) begin
                errors++; $display("FAIL req_mid_enable got=%b want=1", AWGenabled);
            end
            if (i == 2 || i == 3) checks++;
        end
        if (droppedCount !== 16'd1) begin
            errors++; $display("FAIL req_mid_dropped got=%0d want=1", droppedCount);
        end
        checks++;
    endtask

    task automatic test_awg_in_flight();
        bit   av, al, req;
        int   fwd = 0;
        logic [DW-1:0] got[$];
        for (int i = -2; i < 10; i++) begin
            av  = (i >= 0 && i <= 3) || (i >= 5 && i <= 7);
            al  = (i == 3) || (i == 7);
            req = (i >= 1);
            drive_cycle(0, req, 0, 0, '0, av, al, av ? DW'(300 + i) : '0);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL in_flight cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (psTVALID) begin fwd++; got.push_back(psTDATA); end
        end
        if (fwd != 3 || got.size() != 3 || got[0] !== 32'd305 || got[2] !== 32'd307 || droppedCount !== 16'd2) begin
            errors++; $display("FAIL in_flight_summary fwd=%0d drop=%0d want fwd=3 (305..307) drop=2",
                               fwd, droppedCount);
        end
        checks++;
    endtask

    task automatic test_watchdog();
        int t_abort = -1;
        int pulses  = 0;
        repeat (2) begin
            drive_cycle(0, 0, 0, 0, '0, 0, 0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL wd_setup cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        drive_cycle(0, 1, 1, 0, 32'hABCD, 0, 0, '0);
        for (int t = 2; t <= 20; t++) begin
            drive_cycle(0, 1, 0, 0, '0, 0, 0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL wd_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (psAbort) begin pulses++; if (t_abort < 0) t_abort = t; end
        end
        if (t_abort != WD + 1 || pulses != 1 || abortCount !== 16'd1 || AWGenabled !== 1'b1) begin
            errors++; $display("FAIL wd_summary t=%0d pulses=%0d aborts=%0d en=%b want %0d/1/1/1",
                               t_abort, pulses, abortCount, AWGenabled, WD + 1);
        end
        checks++;
    endtask

    task automatic test_request_toggle();
        bit fv, req;
        bit bad_en = 0;
        int fwd = 0;
        for (int i = -2; i < 5; i++) begin
            fv  = (i >= 0 && i <= 2);
            req = (i == 0) || (i == 4);
            drive_cycle(0, req, fv, i == 2, fv ? DW'(400 + i) : '0, 0, 0, '0);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL toggle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (psTVALID) fwd++;
            if (i >= 0 && i <= 3 && AWGenabled) bad_en = 1;
        end
        if (bad_en || fwd != 3 || AWGenabled !== 1'b1) begin
            errors++; $display("FAIL toggle_summary early_en=%b fwd=%0d en=%b want 0/3/1", bad_en, fwd, AWGenabled);
        end
        checks++;
    endtask

    task automatic test_random();
        bit req = 1;
        bit rst, fv, fl, av, al;
        int dens;
        for (int i = 0; i < 3000; i++) begin
            dens = (i < 1000) ? 70 : ((i < 2000) ? 30 : 6);
            if ($urandom_range(0, 39) == 0) req = ~req;
            rst = ($urandom_range(0, 599) == 0);
            fv = ($urandom_range(0, 99) < dens); fl = ($urandom_range(0, 3) == 0);
            av = ($urandom_range(0, 99) < dens); al = ($urandom_range(0, 3) == 0);
            drive_cycle(rst, req, fv, fl, $urandom, av, al, $urandom);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_reset_and_saturation();
        int n = 0;
        while (!AWGenabled && n < 50) begin
            drive_cycle(0, 1, 0, 0, '0, 0, 0, '0);
            n++;
        end
        if (!AWGenabled) begin
            errors++; $display("FAIL sat_grant_timeout en=%b want=1", AWGenabled);
        end
        checks++;
        drive_cycle(0, 1, 0, 0, '0, 1, 0, 32'h11);
        drive_cycle(0, 1, 0, 0, '0, 1, 0, 32'h22);
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL sat_pre_reset got=%h want=%h", obs_vec(), exp_vec());
        end
        checks++;
        drive_cycle(1, 1, 0, 0, '0, 1, 0, 32'h33);
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_mid_awg got=%h want=0", obs_vec());
        end
        checks++;
        for (int i = 0; i < 70000; i++) begin
            drive_cycle(0, 0, 0, 0, '0, 1, 1, DW'(i));
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL saturation cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (droppedCount !== 16'hFFFF || abortCount !== 16'd0 || AWGenabled !== 1'b0) begin
            errors++; $display("FAIL sat_final drop=%h abort=%0d en=%b want FFFF/0/0", droppedCount, abortCount, AWGenabled);
        end
        checks++;
    endtask

    initial begin
        sysReset = 1; AWGrequest = 0;
        fofbTVALID = 0; fofbTLAST = 0; fofbTDATA = '0;
        awgTVALID = 0; awgTLAST = 0; awgTDATA = '0;
        test_reset();
        test_request_mid_packet();
        test_awg_in_flight();
        test_watchdog();
        test_request_toggle();
        test_random();
        test_reset_and_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
